// File: rtl/gameport_axis_cond_if.sv
// Signal bundle between the raw stick sampler, the axis conditioner and the pulse generator.
interface gameport_axis_cond_if;
    logic [15:0] raw_a0;
    logic [15:0] raw_a1;
    logic        sample_stb;
    logic        cal_clear;
    logic [15:0] joya0;
    logic [15:0] joya1;
    logic        out_valid;
    logic        busy;

    // Handshake: sample_stb is a one-cycle request that is taken only while busy is low
    // (requests seen while busy are dropped, never queued); out_valid is a one-cycle
    // pulse with joya0/joya1 valid in that same cycle; the consumer cannot stall it.
    modport master (
        output raw_a0, raw_a1, sample_stb, cal_clear,
        input  joya0, joya1, out_valid, busy
    );

    modport slave (
        input  raw_a0, raw_a1, sample_stb, cal_clear,
        output joya0, joya1, out_valid, busy
    );
endinterface

// File: rtl/gameport_axis_cond.sv
// Analog stick conditioner: per-axis min/max tracking, recentring, span-based gain and saturation.
// Define GAMEPORT_AXIS_IIR_EN to build in the per-axis smoothing filter (coefficient 2^-IIR_SHIFT).
module gameport_axis_cond #(
    parameter int IIR_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    gameport_axis_cond_if.slave  bus,
    output logic [3:0]           dbg_state_o
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_TRK0   = 4'd1, S_CAL0 = 4'd2,
        S_TRK1   = 4'd3, S_CAL1 = 4'd4,
        S_TRK2   = 4'd5, S_CAL2 = 4'd6,
        S_TRK3   = 4'd7, S_CAL3 = 4'd8,
        S_COMMIT = 4'd9
    } state_e;

    localparam logic [7:0] MIN_RST = 8'hF0;
    localparam logic [7:0] MAX_RST = 8'h10;

    state_e state_q, state_d;
    logic [3:0][7:0] raw_q, raw_d, min_q, min_d, max_q, max_d;
    logic [2:0][7:0] staged_q, staged_d;
    logic [15:0]     joya0_q, joya0_d, joya1_q, joya1_d;

    logic              is_trk, is_cal;
    logic [1:0]        axis;
    logic signed [7:0] raw_n, min_n, max_n, min_t, max_t, v, stage_val;
    logic signed [8:0] centre_sum, centre;
    logic [8:0]        span;
    logic signed [10:0] diff, scaled;

    if (IIR_SHIFT < 1 || IIR_SHIFT > 4) begin : g_bad_shift
        $error("gameport_axis_cond: IIR_SHIFT must be in 1..4");
    end

    always_comb begin
        state_d = state_q;
        is_trk  = 1'b0;
        is_cal  = 1'b0;
        axis    = 2'd0;
        case (state_q)
            S_IDLE:  if (bus.sample_stb) state_d = S_TRK0;
            S_TRK0:  begin state_d = S_CAL0;   is_trk = 1'b1; axis = 2'd0; end
            S_CAL0:  begin state_d = S_TRK1;   is_cal = 1'b1; axis = 2'd0; end
            S_TRK1:  begin state_d = S_CAL1;   is_trk = 1'b1; axis = 2'd1; end
            S_CAL1:  begin state_d = S_TRK2;   is_cal = 1'b1; axis = 2'd1; end
            S_TRK2:  begin state_d = S_CAL2;   is_trk = 1'b1; axis = 2'd2; end
            S_CAL2:  begin state_d = S_TRK3;   is_cal = 1'b1; axis = 2'd2; end
            S_TRK3:  begin state_d = S_CAL3;   is_trk = 1'b1; axis = 2'd3; end
            S_CAL3:  begin state_d = S_COMMIT; is_cal = 1'b1; axis = 2'd3; end
            default: state_d = S_IDLE;
        endcase
    end

    // CAL reads min/max straight from the registers, so it sees what TRK wrote one cycle earlier.
    always_comb begin
        raw_n      = raw_q[axis];
        min_n      = min_q[axis];
        max_n      = max_q[axis];
        min_t      = (raw_n < min_n) ? raw_n : min_n;
        max_t      = (raw_n > max_n) ? raw_n : max_n;
        centre_sum = {min_n[7], min_n} + {max_n[7], max_n};
        centre     = centre_sum >>> 1;
        span       = {max_n[7], max_n} - {min_n[7], min_n};
        diff       = {{3{raw_n[7]}}, raw_n} - {{2{centre[8]}}, centre};
        if (span >= 9'd192)     scaled = diff;
        else if (span >= 9'd96) scaled = diff <<< 1;
        else if (span >= 9'd48) scaled = diff <<< 2;
        else                    scaled = diff;
        if (scaled > 11'sd127)       v = 8'sd127;
        else if (scaled < -11'sd127) v = -8'sd127;
        else                         v = scaled[7:0];
    end

`ifdef GAMEPORT_AXIS_IIR_EN
    logic [3:0][9:0]   y_q, y_d;
    logic signed [9:0] y_n, y_err, y_next;

    always_comb begin
        y_n       = y_q[axis];
        y_err     = {{2{v[7]}}, v} - y_n;
        y_next    = y_n + (y_err >>> IIR_SHIFT);
        stage_val = y_next[7:0];
        y_d       = y_q;
        if (bus.cal_clear) y_d = '0;
        else if (is_cal)   y_d[axis] = y_next;
    end

    always_ff @(posedge clk) begin
        if (reset) y_q <= '0;
        else       y_q <= y_d;
    end
`else
    assign stage_val = v;
`endif

    // The last axis goes straight to the outputs so joya changes in the same cycle out_valid rises.
    always_comb begin
        raw_d    = raw_q;
        min_d    = min_q;
        max_d    = max_q;
        staged_d = staged_q;
        joya0_d  = joya0_q;
        joya1_d  = joya1_q;
        if (state_q == S_IDLE && bus.sample_stb) raw_d = {bus.raw_a1, bus.raw_a0};
        if (bus.cal_clear) begin
            min_d = {4{MIN_RST}};
            max_d = {4{MAX_RST}};
        end else if (is_trk) begin
            min_d[axis] = min_t;
            max_d[axis] = max_t;
        end
        if (is_cal) begin
            if (axis == 2'd3) begin
                joya0_d = {staged_q[1], staged_q[0]};
                joya1_d = {stage_val, staged_q[2]};
            end else begin
                staged_d[axis] = stage_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            raw_q    <= '0;
            min_q    <= {4{MIN_RST}};
            max_q    <= {4{MAX_RST}};
            staged_q <= '0;
            joya0_q  <= '0;
            joya1_q  <= '0;
        end else begin
            state_q  <= state_d;
            raw_q    <= raw_d;
            min_q    <= min_d;
            max_q    <= max_d;
            staged_q <= staged_d;
            joya0_q  <= joya0_d;
            joya1_q  <= joya1_d;
        end
    end

    assign bus.joya0     = joya0_q;
    assign bus.joya1     = joya1_q;
    assign bus.out_valid = (state_q == S_COMMIT);
    assign bus.busy      = (state_q != S_IDLE);
    assign dbg_state_o   = state_q;
endmodule

// File: doc/gameport_axis_cond.md
GAMEPORT_AXIS_COND -- requirements
Module: gameport_axis_cond

Interface
REQ-001 Parameter IIR_SHIFT, default 2, range 1-4: smoothing-filter coefficient exponent; the filter step is (x - y) >>> IIR_SHIFT.
REQ-002 clk  input  1  system clock, 50 MHz.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 raw_a0  input  16  P1 raw analog stick: [7:0] X and [15:8] Y, each 8-bit two's complement.
REQ-005 raw_a1  input  16  P2 raw analog stick, same format as raw_a0.
REQ-006 sample_stb  input  1  one-cycle pulse marking a new raw sample.
REQ-007 cal_clear  input  1  level; restores calibration and filter state.
REQ-008 joya0  output  16  conditioned P1 axes, {Y, X}, signed 8-bit each; this is the analog input format of the downstream pulse generator.
REQ-009 joya1  output  16  conditioned P2 axes, same format as joya0.
REQ-010 out_valid  output  1  one-cycle pulse when joya0 and joya1 update.
REQ-011 busy  output  1  high while a sample is being processed.

Function
REQ-012 Processing order: axis index 0 = P1X, 1 = P1Y, 2 = P2X, 3 = P2Y.
REQ-013 FSM states: IDLE; TRK(n) and CAL(n) for n = 0..3; COMMIT. busy = (state != IDLE).
REQ-014 In IDLE, sample_stb latches raw_a0 and raw_a1 into an internal register and moves the FSM to TRK0; sample_stb outside IDLE is ignored (no queueing).
REQ-015 Sequence: TRK(n) -> CAL(n) -> TRK(n+1); CAL3 -> COMMIT -> IDLE. One cycle per state.
REQ-016 TRK(n): min[n] = min(min[n], raw[n]) and max[n] = max(max[n], raw[n]), signed compare.
REQ-017 CAL(n) uses the min/max values already updated in TRK(n).
REQ-018 CAL(n), centre: centre = (min + max) >>> 1, using a 9-bit signed sum and arithmetic shift.
REQ-019 CAL(n), span: span = max - min, 9-bit unsigned.
REQ-020 CAL(n), gain by span: span >= 192 -> x1; 96-191 -> x2; 48-95 -> x4; below 48 -> x1 (uncalibrated).
REQ-021 CAL(n), scaled value: v = (raw - centre) * gain, computed at 11-bit signed width, then saturated to the range -127..+127.
REQ-022 Filter state y[n] is held at 10-bit signed width.
REQ-023 With the filter compiled in: y[n] = y[n] + ((v - y[n]) >>> IIR_SHIFT), and the staged result is y[n][7:0]. With it compiled out, the staged result is v.
REQ-024 COMMIT writes all four staged results to joya0 and joya1 simultaneously and pulses out_valid for that cycle.
REQ-025 Outputs are stable in every cycle other than COMMIT.
REQ-026 Latency: out_valid is high exactly 9 cycles after the cycle in which sample_stb was accepted; busy is high for those 9 cycles, COMMIT included.
REQ-027 cal_clear: sets every min to -16 and every max to +16, and clears y to 0.
REQ-028 cal_clear takes priority over a TRK or filter update in the same cycle.
REQ-029 cal_clear does not abort processing in flight; later CAL states use the cleared values.
REQ-030 Simultaneous sample_stb and cal_clear in IDLE: the sample is accepted and processed against the cleared calibration.

Reset
REQ-031 Reset return values: state IDLE, joya0 = joya1 = 16'h0000, out_valid = 0, busy = 0, all min = -16, all max = +16, all y = 0.
REQ-032 Reset asserted mid-sequence abandons the sample: no out_valid is produced and the outputs return to 0.
REQ-033 Reset has priority over all other inputs.

Configuration
REQ-034 Macro GAMEPORT_AXIS_IIR_EN. Defined: the REQ-023 filter is present. Undefined: no filter registers exist and the staged result is v; latency is unchanged.

Verification
REQ-035 Reset, then strobe with raw = 0 on all axes -> out_valid 9 cycles later, joya0 = joya1 = 0000, busy high for 9 cycles.
REQ-036 From reset, filter off, P1X = +100 -> max 100, span 116, gain x2, centre 42 -> joya0[7:0] = 8'h74.
REQ-037 From reset, filter off: P1Y = +40 -> 8'h70; then P1Y = +47 -> 8'h7F (saturated).
REQ-038 Second sample_stb 3 cycles after the first -> exactly one out_valid, and the output reflects the first sample only.
REQ-039 After REQ-036, assert cal_clear for 1 cycle, then strobe with raw = 0 -> joya0 = 0000.
REQ-040 Filter compiled in, IIR_SHIFT = 2, P1X = +100 repeated -> joya0[7:0] = 8'h1D, then 8'h32, converging towards 8'h74.
